// File: rtl/morse_pattern_player_pkg.sv
// Shared types and helpers for the Morse/LED sequence player.
package morse_pkg;

   typedef enum logic [1:0] {IDLE, MARK, SPACE, DONE} state_e;

   // Per-bit LED off level (active-low bank)
   localparam logic LED_OFF_BIT = 1'b1;

   // Width needed to hold the longest of the dot, dash and gap unit counts
   function automatic int unit_w(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/morse_pattern_player_tick_gen.sv
// Time-unit prescaler: one-cycle tick every TICK_DIV+1 enabled cycles.
module tick_gen #(
   parameter int TICK_DIV = 5_999_999
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int CW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_term;

   assign w_term = (r_cnt == CW'(TICK_DIV));
   assign o_tick = i_en && w_term;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_en)
         r_cnt <= w_term ? '0 : r_cnt + CW'(1);
   end

endmodule

// File: rtl/morse_pattern_player.sv
// Plays a latched dot/dash sequence on an active-low LED bank with
// start/busy/done handshake, abort and optional repeat.
module morse_pattern_player
   import morse_pkg::*;
#(
   parameter int TICK_DIV   = 5_999_999,
   parameter int MAX_SYM    = 8,
   parameter int LED_W      = 8,
   parameter int DOT_UNITS  = 2,
   parameter int DASH_UNITS = 4,
   parameter int GAP_UNITS  = 1,
   localparam int LEN_W     = $clog2(MAX_SYM + 1),
   localparam int IDX_W     = (MAX_SYM > 1) ? $clog2(MAX_SYM) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic [MAX_SYM-1:0] i_code,
   input  logic [LEN_W-1:0]   i_len,
   input  logic [LED_W-1:0]   i_dot_pat,
   input  logic [LED_W-1:0]   i_dash_pat,
   input  logic               i_repeat_en,
   input  logic               i_abort,
   output logic               o_busy,
   output logic               o_done,
   output logic [IDX_W-1:0]   o_sym_idx,
   output logic [LED_W-1:0]   o_pin_out
);

   localparam int                UW    = unit_w(DOT_UNITS, DASH_UNITS, GAP_UNITS);
   localparam logic [LED_W-1:0] W_OFF = {LED_W{LED_OFF_BIT}};

   state_e             r_state;
   logic [MAX_SYM-1:0] r_code;
   logic [LEN_W-1:0]   r_len;
   logic [LED_W-1:0]   r_dot, r_dash, r_pin;
   logic               r_rep, r_busy, r_done;
   logic [IDX_W-1:0]   r_sym_idx;
   logic [UW-1:0]      r_unit;

   logic               w_tick, w_end, w_last, w_tclr;
   logic [UW-1:0]      w_units;
   logic [IDX_W-1:0]   w_nidx;
   logic [LEN_W-1:0]   w_len_in;

   assign w_units  = (r_state == SPACE) ? UW'(GAP_UNITS)
                   : (r_code[r_sym_idx] ? UW'(DASH_UNITS) : UW'(DOT_UNITS));
   assign w_end    = w_tick && (r_unit == w_units - UW'(1));
   assign w_last   = (LEN_W'(r_sym_idx) + LEN_W'(1)) == r_len;
   assign w_nidx   = r_sym_idx + IDX_W'(1);
   assign w_len_in = (i_len > LEN_W'(MAX_SYM)) ? LEN_W'(MAX_SYM) : i_len;
   // Prescaler restarts on every state entry; held clear outside MARK/SPACE
   assign w_tclr   = !((r_state == MARK) || (r_state == SPACE)) || w_end;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (r_busy),
      .i_clr  (w_tclr),
      .o_tick (w_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_code    <= '0;
         r_len     <= '0;
         r_dot     <= W_OFF;
         r_dash    <= W_OFF;
         r_rep     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_sym_idx <= '0;
         r_unit    <= '0;
         r_pin     <= W_OFF;
      end else if (r_state != IDLE && i_abort) begin
         r_state   <= IDLE;
         r_rep     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_sym_idx <= '0;
         r_unit    <= '0;
         r_pin     <= W_OFF;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start && !i_abort) begin
                  r_code    <= i_code;
                  r_len     <= w_len_in;
                  r_dot     <= i_dot_pat;
                  r_dash    <= i_dash_pat;
                  r_rep     <= i_repeat_en;
                  r_busy    <= 1'b1;
                  r_sym_idx <= '0;
                  r_unit    <= '0;
                  if (w_len_in != '0) begin
                     r_state <= MARK;
                     r_pin   <= i_code[0] ? i_dash_pat : i_dot_pat;
                  end else begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                     r_pin   <= W_OFF;
                  end
               end
            end
            MARK: begin
               if (w_end) begin
                  r_unit  <= '0;
                  r_state <= SPACE;
                  r_pin   <= W_OFF;
               end else if (w_tick) begin
                  r_unit <= r_unit + UW'(1);
               end
            end
            SPACE: begin
               if (w_end) begin
                  r_unit <= '0;
                  if (w_last) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_sym_idx <= w_nidx;
                     r_state   <= MARK;
                     r_pin     <= r_code[w_nidx] ? r_dash : r_dot;
                  end
               end else if (w_tick) begin
                  r_unit <= r_unit + UW'(1);
               end
            end
            DONE: begin
               r_sym_idx <= '0;
               r_unit    <= '0;
               // An empty sequence never repeats
               if (r_rep && r_len != '0) begin
                  r_state <= MARK;
                  r_pin   <= r_code[0] ? r_dash : r_dot;
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_pin   <= W_OFF;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_sym_idx = r_sym_idx;
   assign o_pin_out = r_pin;

endmodule

// File: tb/tb_morse_pattern_player.sv
// Directed bench for morse_pattern_player at 4 cycles per time unit.
module tb_morse_pattern_player;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       i_start = 1'b0;
   logic [7:0] i_code = '0;
   logic [3:0] i_len = '0;
   logic [7:0] i_dot_pat = 8'hFE;
   logic [7:0] i_dash_pat = 8'h0F;
   logic       i_repeat_en = 1'b0;
   logic       i_abort = 1'b0;
   logic       o_busy, o_done;
   logic [2:0] o_sym_idx;
   logic [7:0] o_pin_out;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   morse_pattern_player #(
      .TICK_DIV(3), .MAX_SYM(8), .LED_W(8),
      .DOT_UNITS(2), .DASH_UNITS(4), .GAP_UNITS(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_code(i_code), .i_len(i_len),
      .i_dot_pat(i_dot_pat), .i_dash_pat(i_dash_pat), .i_repeat_en(i_repeat_en),
      .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done), .o_sym_idx(o_sym_idx),
      .o_pin_out(o_pin_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "/busy"}, 32'(o_busy), 0);
      chk({tag, "/done"}, 32'(o_done), 0);
      chk({tag, "/pin"}, 32'(o_pin_out), 32'hFF);
      chk({tag, "/sym"}, 32'(o_sym_idx), 0);
   endtask

   task automatic go(input logic [7:0] code, input logic [3:0] len, input logic rep);
      i_code = code; i_len = len; i_dot_pat = 8'hFE; i_dash_pat = 8'h0F;
      i_repeat_en = rep; i_start = 1'b1;
      step();
      i_start = 1'b0;
   endtask

   // Checks one full pass starting at its first MARK cycle, ending one cycle after DONE.
   // At cycle 'inj' a competing start with different inputs is pulsed.
   task automatic play(input logic [7:0] code, input int len, input string tag, input int inj);
      int cyc = 0;
      int mk;
      logic [7:0] pat;
      for (int s = 0; s < len; s++) begin
         mk  = code[s] ? 16 : 8;
         pat = code[s] ? 8'h0F : 8'hFE;
         for (int k = 0; k < mk + 4; k++) begin
            cyc++;
            if (cyc == inj) begin
               i_start = 1'b1; i_code = 8'hFF; i_len = 4'd8;
               i_dot_pat = 8'h00; i_dash_pat = 8'h00;
            end else begin
               i_start = 1'b0;
            end
            chk($sformatf("%s/c%0d/pin", tag, cyc), 32'(o_pin_out), (k < mk) ? 32'(pat) : 32'hFF);
            chk($sformatf("%s/c%0d/busy", tag, cyc), 32'(o_busy), 1);
            chk($sformatf("%s/c%0d/done", tag, cyc), 32'(o_done), 0);
            chk($sformatf("%s/c%0d/sym", tag, cyc), 32'(o_sym_idx), 32'(s));
            step();
         end
      end
      i_start = 1'b0;
      chk({tag, "/done_pulse"}, 32'(o_done), 1);
      chk({tag, "/done_busy"}, 32'(o_busy), 1);
      chk({tag, "/done_pin"}, 32'(o_pin_out), 32'hFF);
      step();
   endtask

   initial begin
      // Asynchronous reset visible before any clock edge
      #1 rst_n = 1'b0;
      #1 chk_idle("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk_idle("post_reset");

      // S: three dots, 37 busy cycles
      go(8'h00, 4'd3, 1'b0);
      play(8'h00, 3, "S", 0);
      chk_idle("S_end");

      // O: three dashes, 61 busy cycles
      go(8'h07, 4'd3, 1'b0);
      play(8'h07, 3, "O", 0);
      chk_idle("O_end");

      // Mixed dot/dash/dot
      go(8'h02, 4'd3, 1'b0);
      play(8'h02, 3, "MIX", 0);
      chk_idle("MIX_end");

      // Abort five cycles into the first dash
      go(8'h07, 4'd3, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("ab_pre%0d/pin", i), 32'(o_pin_out), 32'h0F);
         step();
      end
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      chk_idle("abort");
      step();
      chk_idle("abort_hold");
      go(8'h07, 4'd3, 1'b0);
      play(8'h07, 3, "O_replay", 0);
      chk_idle("O_replay_end");

      // Start together with abort in IDLE is ignored
      i_abort = 1'b1;
      go(8'h00, 4'd3, 1'b0);
      i_abort = 1'b0;
      chk_idle("start_abort");

      // Competing start while busy changes nothing
      go(8'h00, 4'd3, 1'b0);
      play(8'h00, 3, "S_inj", 10);
      chk_idle("S_inj_end");

      // Empty sequence: one DONE cycle
      go(8'h00, 4'd0, 1'b0);
      chk("len0/busy", 32'(o_busy), 1);
      chk("len0/done", 32'(o_done), 1);
      chk("len0/pin", 32'(o_pin_out), 32'hFF);
      step();
      chk_idle("len0_end");

      // Empty sequence with repeat does not loop
      go(8'h00, 4'd0, 1'b1);
      chk("len0r/done", 32'(o_done), 1);
      step();
      chk_idle("len0r_end");

      // Length above MAX_SYM plays eight symbols
      go(8'h80, 4'd15, 1'b0);
      play(8'h80, 8, "CLAMP", 0);
      chk_idle("CLAMP_end");

      // Repeat: passes back-to-back until abort; input repeat change is ignored
      go(8'h00, 4'd3, 1'b1);
      i_repeat_en = 1'b0;
      play(8'h00, 3, "REP1", 0);
      play(8'h00, 3, "REP2", 0);
      for (int i = 0; i < 5; i++) step();
      chk("rep3/busy", 32'(o_busy), 1);
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      chk_idle("rep_abort");
      step();
      chk_idle("rep_abort_hold");

      // Asynchronous reset during MARK
      go(8'h00, 4'd3, 1'b0);
      step(); step(); step();
      chk("prerst/pin", 32'(o_pin_out), 32'hFE);
      #2 rst_n = 1'b0;
      #1 chk_idle("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk_idle("midrst_release");
      go(8'h02, 4'd3, 1'b0);
      play(8'h02, 3, "MIX_after_rst", 0);
      chk_idle("MIX_after_rst_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/morse_pattern_player.md
Name: morse_pattern_player

Overview:
Parametrised LED sequence player. It plays a variable-length sequence of dot and dash symbols, for example Morse "S" (three dots) or "O" (three dashes), on an active-low LED bank. Dot and dash LED patterns and durations are configurable. A start/busy/done handshake drives it, with abort and optional repeat. It sits between the control FSM (FIFO consumer) and the LED pins.

Parameters:
TICK_DIV, 5_999_999, prescaler terminal count; one time unit = TICK_DIV+1 clk cycles (0.5 s at 12 MHz)
MAX_SYM, 8, maximum symbols per sequence
LED_W, 8, LED bank width
DOT_UNITS, 2, dot mark length in units (>=1)
DASH_UNITS, 4, dash mark length in units (>=1)
GAP_UNITS, 1, space after every symbol in units (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request pulse; sampled only in IDLE
code  in  MAX_SYM  symbol bits, bit0 played first; 1=dash, 0=dot
len  in  $clog2(MAX_SYM+1)  number of symbols (0..MAX_SYM)
dot_pat  in  LED_W  active-low LED value during dot mark
dash_pat  in  LED_W  active-low LED value during dash mark
repeat_en  in  1  replay sequence until abort
abort  in  1  stop immediately
busy  out  1  high from cycle after accepted start until return to IDLE
done  out  1  one-cycle pulse at end of each pass
sym_idx  out  $clog2(MAX_SYM)  index of symbol being played
pin_out  out  LED_W  LED drive, active-low

Behaviour:
- Reset values: pin_out = all ones; busy=0; done=0; sym_idx=0; state IDLE; counters 0.
- Reset mid-operation: the asynchronous reset forces all reset values immediately. No done pulse is produced.
- States: IDLE, MARK, SPACE, DONE.
- IDLE, on start=1 and abort=0:
  - latch code, len, dot_pat, dash_pat, repeat_en;
  - next state is MARK if len>0, else DONE.
  - start with abort in the same cycle: start ignored.
- MARK:
  - pin_out = latched dash_pat if code[sym_idx], else dot_pat.
  - Lasts exactly units*(TICK_DIV+1) cycles, where units = DASH_UNITS or DOT_UNITS.
  - Then go to SPACE.
- SPACE:
  - pin_out = all ones for GAP_UNITS*(TICK_DIV+1) cycles.
  - If sym_idx==len-1: go to DONE. Otherwise sym_idx+1, go to MARK.
- DONE:
  - One cycle with done=1, busy=1, pin_out all ones.
  - If latched repeat_en: sym_idx=0, go to MARK (or DONE again if len=0 and repeat set: illegal, treat as no repeat).
  - Else go to IDLE.
- Tick prescaler:
  - counts only while busy;
  - cleared on every state entry, so each unit is a full TICK_DIV+1 cycles;
  - unit counter cleared on state entry and compared against the state's unit count.
- Latency:
  - start sampled at edge 0 → busy and first MARK pattern visible after edge 1.
  - Busy duration per pass = sum(mark+gap cycles) + 1.
- abort=1 in MARK/SPACE/DONE:
  - next edge → IDLE, pin_out all ones, busy=0, sym_idx=0;
  - no done pulse; abort also clears repeat.
- start while busy: ignored; latched inputs are not updated.
- Changes on code/len/patterns while busy have no effect.
- len>MAX_SYM is clamped to MAX_SYM.

Decomposition:
- Package morse_pkg: state enum (IDLE, MARK, SPACE, DONE), LED_OFF all-ones constant, unit-counter width function max(DOT, DASH, GAP).
- Sub-module tick_gen: prescaler with enable and synchronous clear. Outputs a 1-cycle tick at count==TICK_DIV.

Test Plan:
Common setup: TICK_DIV=3 (4 cycles/unit), DOT=2, DASH=4, GAP=1, MAX_SYM=8.
1. "S": len=3, code=0, dot_pat=FE → pin_out FE 8 cycles / FF 4 cycles, ×3. Then done pulse in cycle 37 after busy rises; busy low after 37 cycles.
2. "O": len=3, code=3'b111, dash_pat=0F → 0F 16 cycles / FF 4 cycles, ×3. done after 60 cycles; sym_idx steps 0,1,2.
3. Mixed: code=3'b010, len=3 → FE 8, FF 4, 0F 16, FF 4, FE 8, FF 4, then done.
4. Abort 5 cycles into the dash of test 2:
   - next cycle pin_out=FF, busy=0, no done;
   - a new start replays from sym_idx=0 with full timing.
5. Edge and repeat cases:
   - start pulsed mid-sequence → timing unchanged;
   - len=0 start → busy for 1 cycle with done=1, pin_out FF throughout;
   - repeat_en=1 with test 1 → done every 37 cycles, busy stays 1 until abort.
6. rst_n low during MARK → pin_out=FF, busy=0 immediately (before next clk edge). After release, IDLE; a new start works.
